// File: rtl/mem_sram_if_pkg.sv
// rtl/mem_sram_if_pkg.sv - state encodings and constants for the MEM-stage SRAM interface
package mem_sram_if_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_HOLD  = 3'd4,
    ST_DONE     = 3'd5
  } sram_state_e;

  localparam logic [3:0] BE_N_IDLE = 4'hF;

  // Wide enough to hold the larger of the two wait counts without wrapping.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - loadable down-counter with zero flag, shared by read wait and write pulse
module mem_wait_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_sram_if.sv
// rtl/mem_sram_if.sv - MEM-stage to single-port 32-bit SRAM bus interface with stall, hold and flush
module mem_sram_if
  import mem_sram_if_pkg::*;
#(
  parameter int unsigned ADDR_W   = 20,
  parameter int unsigned RD_WAIT  = 2,
  parameter int unsigned WR_PULSE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [31:0]       mem_data_i,
  input  logic              mem_adv_i,
  input  logic              flush_i,
  output logic [31:0]       mem_data_o,
  output logic              done_o,
  output logic              stallreq_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [31:0]       sram_data_o,
  input  logic [31:0]       sram_data_i,
  output logic              sram_oe_t,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n
);

  localparam int unsigned CNT_W = cnt_width(RD_WAIT, WR_PULSE);

  sram_state_e       state_q, state_d;
  logic              flushed_q, flushed_d;
  logic [3:0]        sel_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, rdata_q;
  logic              ce_n_q, oe_n_q, we_n_q, oe_t_q;
  logic [3:0]        be_n_q;

  logic              latch, capture, tmr_load, tmr_dec, tmr_zero;
  logic [CNT_W-1:0]  tmr_val;
  logic              active_d;
  logic [3:0]        sel_cur;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{mem_addr_i[31:ADDR_W+2], mem_addr_i[1:0]};

  mem_wait_timer #(.W(CNT_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    flushed_d = flushed_q;
    latch     = 1'b0;
    capture   = 1'b0;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    tmr_val   = '0;
    case (state_q)
      ST_IDLE: begin
        flushed_d = 1'b0;
        if (mem_ce_i && !flush_i) begin
          latch = 1'b1;
          if (mem_we_i) begin
            state_d = ST_WR_SETUP;
          end else begin
            state_d  = ST_RD;
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(RD_WAIT - 1);
          end
        end
      end
      ST_RD: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else if (tmr_zero) begin
          capture = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_WR_SETUP: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d  = ST_WR_PULSE;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(WR_PULSE - 1);
        end
      end
      ST_WR_PULSE: begin
        // A flush here must not truncate the pulse; remember it and skip DONE later.
        if (flush_i) flushed_d = 1'b1;
        if (tmr_zero) state_d = ST_WR_HOLD;
        else          tmr_dec = 1'b1;
      end
      ST_WR_HOLD: begin
        state_d = (flushed_q || flush_i) ? ST_IDLE : ST_DONE;
      end
      ST_DONE: begin
        if (flush_i || mem_adv_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign active_d = (state_d == ST_RD) || (state_d == ST_WR_SETUP) ||
                    (state_d == ST_WR_PULSE) || (state_d == ST_WR_HOLD);
  assign sel_cur  = latch ? mem_sel_i : sel_q;

  // Strobes are registered from the next state so they line up with state_q glitch-free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      flushed_q <= 1'b0;
      sel_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      oe_t_q    <= 1'b0;
      be_n_q    <= BE_N_IDLE;
    end else begin
      state_q   <= state_d;
      flushed_q <= flushed_d;
      if (latch) begin
        sel_q   <= mem_sel_i;
        addr_q  <= mem_addr_i[ADDR_W+1:2];
        wdata_q <= mem_data_i;
      end
      if (capture) rdata_q <= sram_data_i;
      ce_n_q <= !active_d;
      oe_n_q <= (state_d != ST_RD);
      we_n_q <= (state_d != ST_WR_PULSE);
      oe_t_q <= active_d && (state_d != ST_RD);
      be_n_q <= active_d ? ~sel_cur : BE_N_IDLE;
    end
  end

  always_comb begin
    stallreq_o = 1'b0;
    if (!flush_i) begin
      case (state_q)
        ST_IDLE:                                        stallreq_o = mem_ce_i;
        ST_RD, ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD:    stallreq_o = 1'b1;
        default:                                        stallreq_o = 1'b0;
      endcase
    end
  end

  assign done_o      = (state_q == ST_DONE);
  assign mem_data_o  = rdata_q;
  assign sram_addr_o = addr_q;
  assign sram_data_o = wdata_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;
  assign sram_oe_t   = oe_t_q;
  assign sram_be_n   = be_n_q;

endmodule
